mc_control_fsm: RTL and testbench

Main control unit for the multi-cycle MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback states. It consumes `op`, `funct` and `zero` from the datapath and drives every datapath enable and mux select, plus `memwrite` to the unified instruction/data memory. It sits directly beside the datapath and is the only source of its control inputs.

---
 rtl/mc_control_fsm.sv | 171 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Main control FSM for the multi-cycle MIPS core: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath enable and select.
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_pcwrite;
  logic        w_branch;
  logic [1:0]  w_aluop;

  // State register with synchronous active-low reset into FETCH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode; aluop 11 marks an illegal state so
  // that alucontrol also reads zero there.
  always_comb begin
    w_next    = S_FETCH;
    w_pcwrite = 1'b0;
    w_branch  = 1'b0;
    w_aluop   = 2'b00;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    alusrca   = 1'b0;
    iord      = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        irwrite   = 1'b1;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEXEC;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = 2'b01;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: begin
        w_aluop = 2'b11;
      end
    endcase
  end

  // ALU operation decode from aluop and the R-type function field.
  always_comb begin
    alucontrol = 3'b000;
    case (w_aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  // PC enable: unconditional write or taken branch, zero is live.
  assign pcen  = w_pcwrite | (w_branch & zero);
  assign state = STATE_W'(r_state);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: a path-list model of instruction
// flow plus a per-state output table, compared every cycle, and directed
// instruction sequences with hand-computed literal expectations.
module tb_mc_control_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       pcwrite, branch, irwrite, regwrite, memwrite;
    logic       alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc, aluop;
  } row_t;

  row_t tbl [16];
  int   m_cur = 0;
  int   m_q[$];
  bit   m_en = 0;

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    tbl[0].alusrcb = 2'b01; tbl[0].irwrite = 1; tbl[0].pcwrite = 1;
    tbl[1].alusrcb = 2'b11;
    tbl[2].alusrca = 1; tbl[2].alusrcb = 2'b10;
    tbl[3].iord = 1;
    tbl[4].memtoreg = 1; tbl[4].regwrite = 1;
    tbl[5].iord = 1; tbl[5].memwrite = 1;
    tbl[6].alusrca = 1; tbl[6].aluop = 2'b10;
    tbl[7].regdst = 1; tbl[7].regwrite = 1;
    tbl[8].alusrca = 1; tbl[8].aluop = 2'b01; tbl[8].pcsrc = 2'b01; tbl[8].branch = 1;
    tbl[9].alusrca = 1; tbl[9].alusrcb = 2'b10;
    tbl[10].regwrite = 1;
    tbl[11].pcsrc = 2'b10; tbl[11].pcwrite = 1;
  end

  function automatic logic [2:0] alu_of(input logic [1:0] aop, input logic [5:0] f);
    if (aop == 2'b00) return 3'b010;
    if (aop == 2'b01) return 3'b110;
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  // Model advance: DECODE expands the opcode into its remaining state path.
  always @(posedge clk) begin
    if (!reset) begin
      m_cur = 0;
      m_q.delete();
      m_en  = 1;
    end else if (m_cur == 0) begin
      m_cur = 1;
    end else begin
      if (m_cur == 1) begin
        case (op)
          6'b100011: m_q = '{2, 3, 4};
          6'b101011: m_q = '{2, 5};
          6'b000000: m_q = '{6, 7};
          6'b000100: m_q = '{8};
          6'b001000: m_q = '{9, 10};
          6'b000010: m_q = '{11};
          default:   m_q.delete();
        endcase
      end
      m_cur = (m_q.size() != 0) ? m_q.pop_front() : 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_en) begin
      row_t r;
      logic [14:0] e, a;
      r = tbl[m_cur];
      e = {r.pcwrite | (r.branch & zero), r.irwrite, r.regwrite, r.memwrite,
           r.alusrca, r.iord, r.memtoreg, r.regdst, r.alusrcb, r.pcsrc,
           alu_of(r.aluop, funct)};
      a = {pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst,
           alusrcb, pcsrc, alucontrol};
      check("model_state", 16'(state), 16'(m_cur));
      check("model_outputs", 16'(a), 16'(e));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] s_pcen [16], s_regwrite [16], s_memwrite [16], s_iord [16];
  logic [15:0] s_memtoreg [16], s_regdst [16], s_pcsrc [16], s_alu [16];

  // Start in a FETCH cycle; run one instruction and record per-state outputs.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int exp_cpi);
    int cnt = 1;
    bit done = 0;
    op = o; funct = f; zero = z;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      if (state == 4'd0) done = 1;
      else begin
        cnt++;
        s_pcen[state] = 16'(pcen);       s_regwrite[state] = 16'(regwrite);
        s_memwrite[state] = 16'(memwrite); s_iord[state] = 16'(iord);
        s_memtoreg[state] = 16'(memtoreg); s_regdst[state] = 16'(regdst);
        s_pcsrc[state] = 16'(pcsrc);     s_alu[state] = 16'(alucontrol);
      end
    end
    if (!done) check({name, "_timeout"}, 16'd1, 16'd0);
    check({name, "_cpi"}, 16'(cnt), 16'(exp_cpi));
    #1;
  endtask

  task automatic wait_state(input logic [3:0] s);
    bit hit = 0;
    for (int i = 0; i < 12 && !hit; i++) begin
      @(negedge clk);
      if (state == s) hit = 1;
    end
    if (!hit) check("wait_state_timeout", 16'(state), 16'(s));
  endtask

  initial begin
    reset = 1'b0; op = 6'b111111; funct = 6'b000000; zero = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_pcen[i] = '0; s_regwrite[i] = '0; s_memwrite[i] = '0; s_iord[i] = '0;
      s_memtoreg[i] = '0; s_regdst[i] = '0; s_pcsrc[i] = '0; s_alu[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_state", 16'(state), 16'd0);
    check("rst_irwrite", 16'(irwrite), 16'd1);
    check("rst_pcen", 16'(pcen), 16'd1);
    check("rst_regwrite", 16'(regwrite), 16'd0);
    check("rst_memwrite", 16'(memwrite), 16'd0);
    check("rst_alucontrol", 16'(alucontrol), 16'b010);
    #1 reset = 1'b1;

    run_instr("slt", 6'b000000, 6'b101010, 1'b0, 4);
    check("slt_alu", s_alu[6], 16'b111);
    check("slt_regwrite", s_regwrite[7], 16'd1);
    check("slt_regdst", s_regdst[7], 16'd1);

    run_instr("or", 6'b000000, 6'b100101, 1'b0, 4);
    check("or_alu", s_alu[6], 16'b001);
    run_instr("sub", 6'b000000, 6'b100010, 1'b1, 4);
    check("sub_alu", s_alu[6], 16'b110);
    run_instr("rbad", 6'b000000, 6'b111000, 1'b0, 4);
    check("rbad_alu", s_alu[6], 16'b000);

    run_instr("lw", 6'b100011, 6'b000000, 1'b0, 5);
    check("lw_memtoreg", s_memtoreg[4], 16'd1);
    check("lw_regwrite", s_regwrite[4], 16'd1);
    check("lw_memrd_iord", s_iord[3], 16'd1);
    run_instr("sw", 6'b101011, 6'b000000, 1'b0, 4);
    check("sw_memwrite", s_memwrite[5], 16'd1);
    check("sw_iord", s_iord[5], 16'd1);

    run_instr("beq_t", 6'b000100, 6'b000000, 1'b1, 3);
    check("beq_t_pcen", s_pcen[8], 16'd1);
    check("beq_t_pcsrc", s_pcsrc[8], 16'b01);
    check("beq_t_alu", s_alu[8], 16'b110);
    run_instr("beq_nt", 6'b000100, 6'b000000, 1'b0, 3);
    check("beq_nt_pcen", s_pcen[8], 16'd0);

    run_instr("j", 6'b000010, 6'b000000, 1'b0, 3);
    check("j_pcen", s_pcen[11], 16'd1);
    check("j_pcsrc", s_pcsrc[11], 16'b10);
    run_instr("addi", 6'b001000, 6'b000000, 1'b0, 4);
    check("addi_regdst", s_regdst[10], 16'd0);
    check("addi_regwrite", s_regwrite[10], 16'd1);
    run_instr("illegal", 6'b111111, 6'b000000, 1'b0, 2);

    // zero toggling inside BRANCH drives pcen combinationally
    op = 6'b000100; zero = 1'b0;
    wait_state(4'd8);
    #1 zero = 1'b1;
    #1 check("beq_zero_rise", 16'(pcen), 16'd1);
    zero = 1'b0;
    #1 check("beq_zero_fall", 16'(pcen), 16'd0);
    wait_state(4'd0);
    #1;

    // reset during lw MEMRD aborts before writeback
    op = 6'b100011;
    wait_state(4'd3);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_state", 16'(state), 16'd0);
    check("abort_regwrite", 16'(regwrite), 16'd0);
    check("abort_memwrite", 16'(memwrite), 16'd0);
    #1 reset = 1'b1; op = 6'b111111;
    run_instr("post_abort", 6'b001000, 6'b000000, 1'b0, 4);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
